// File: rtl/skid_register.sv
// rtl/skid_register.sv - two-entry skid register with fully registered upstream ready
module skid_register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] skid_data;
    logic             push;
    logic             pop;

    // Ready depends only on held state, never on out_ready.
    assign in_ready = (state != FULL) && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign count    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        out_data <= in_data;
                    end else if (push) begin
                        skid_data <= in_data;
                        state     <= FULL;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    // The skid beat is older than anything upstream, so it moves to main.
                    if (pop) begin
                        out_data <= skid_data;
                        state    <= ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skid_register.sv
// tb/tb_skid_register.sv - randomized and directed bench for skid_register against a queue model
module tb_skid_register;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;

    logic [WIDTH-1:0] q[$];

    skid_register #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: compare at negedge against the queue, then advance the queue at posedge.
    task automatic cycle();
        logic exp_rdy;
        logic do_push;
        logic do_pop;
        @(negedge clk);
        exp_rdy = (q.size() < 2) && !rst;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("count", 32'(count), 32'(q.size()));
        if (q.size() != 0)
            check("out_data", 32'(out_data), 32'(q[0]));
        do_push = in_valid && exp_rdy;
        do_pop  = (q.size() != 0) && out_ready;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                n_pop++;
            end
            if (do_push)
                q.push_back(in_data);
        end
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4 && q.size() != 0; i++)
            cycle();
        check("drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int pops0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        cycle();
        check("reset_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        cycle();

        // Back-to-back flow-through with the reader always ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i * 8'h11);
            cycle();
        end
        drain();

        // Fill to FULL, hold a blocked beat upstream, then release.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA1;
        cycle();
        in_data   = 8'hA2;
        cycle();
        check("full_count", 32'(count), 32'd2);
        in_data = 8'hFF;
        for (int i = 0; i < 3; i++)
            cycle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        check("ready_after_first_pop", 32'(in_ready), 32'd1);
        drain();

        // Reset while FULL discards both held beats.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        cycle();
        in_data   = 8'h5B;
        cycle();
        rst = 1'b1;
        cycle();
        rst      = 1'b0;
        in_valid = 1'b0;
        cycle();
        check("post_rst_out_data", 32'(out_data), 32'd0);

        // Sustained one beat per cycle.
        out_ready = 1'b1;
        pops0     = n_pop;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check("stream_pops", 32'(n_pop - pops0), 32'd8);
        drain();

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = 8'($urandom);
            if ($urandom_range(0, 999) == 0)
                rst = 1'b1;
            cycle();
            rst = 1'b0;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
